crop_stream_reader: RTL and testbench

Reads a cropped image buffer back out of pixel memory and streams it, one 16-bit colour component per beat, over a valid/ready interface toward downstream consumers (UART/display/compare logic). It is the read-side counterpart of the cropping writer. It walks the same column-major, RGB-interleaved layout starting at the header offset, with one-cycle-latency memory reads and a 2-entry output buffer that absorbs backpressure without dropping or duplicating data.

---
 rtl/crop_stream_reader.sv | 175 +++++++++++++++++
 tb/tb_crop_stream_reader.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/crop_stream_reader.sv
// Streams a cropped, column-major RGB image out of pixel memory over valid/ready.
// Optional CROP_READER_ROW_PAD_EN: skip padding words after each column (stride rounded up to 4).
module crop_stream_reader #(
  parameter int BASE_ADDR = 54,
  parameter int ADDR_W    = 24,
  parameter int DATA_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [10:0]       cols,
  input  logic [10:0]       rows,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sol,
  output logic              out_last
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t state, state_nxt;

  logic [10:0]       rows_r;
  logic [23:0]       count_m1;
  logic [23:0]       issue_idx;
  logic [10:0]       y_cnt;
  logic [1:0]        c_cnt;
  logic [ADDR_W-1:0] addr_r;

  logic              inflight;
  logic              inflight_sol;
  logic              inflight_last;

  logic [DATA_W-1:0] fifo_data [2];
  logic [1:0]        fifo_sol;
  logic [1:0]        fifo_last;
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        occ;

  logic              start_ok;
  logic              zero_dim;
  logic              pop;
  logic              last_issue;
  logic              y_wrap;
  logic [2:0]        load;

`ifdef CROP_READER_ROW_PAD_EN
  logic [1:0]        pad_r;
  logic [3:0]        rows_x3;
  logic              col_end;
  assign rows_x3 = {2'b00, rows[1:0]} * 4'd3;
  assign col_end = (c_cnt == 2'd2) && y_wrap;
`endif

  assign start_ok   = start && ((state == IDLE) || (state == DONE));
  assign zero_dim   = (cols == 11'd0) || (rows == 11'd0);
  assign out_valid  = (occ != 2'd0);
  assign pop        = out_valid && out_ready;
  assign last_issue = (issue_idx == count_m1);
  assign y_wrap     = (y_cnt == rows_r - 11'd1);
  // A beat leaving this cycle frees a slot, which keeps the stream gap-free at full rate.
  assign load       = {1'b0, occ} - {2'b00, pop} + {2'b00, inflight};

  assign out_data = out_valid ? fifo_data[rd_ptr] : '0;
  assign out_sol  = out_valid && fifo_sol[rd_ptr];
  assign out_last = out_valid && fifo_last[rd_ptr];
  assign rd_addr  = addr_r;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = zero_dim ? DONE : FETCH;
      end
      FETCH: begin
        busy  = 1'b1;
        rd_en = (load < 3'd2);
        if (rd_en && last_issue) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (!inflight && ((occ == 2'd0) || ((occ == 2'd1) && pop))) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_nxt = zero_dim ? DONE : FETCH;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Element walk: component, then row, then column; address is a running register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rows_r        <= '0;
      count_m1      <= '0;
      issue_idx     <= '0;
      y_cnt         <= '0;
      c_cnt         <= '0;
      addr_r        <= ADDR_W'(BASE_ADDR);
      inflight      <= 1'b0;
      inflight_sol  <= 1'b0;
      inflight_last <= 1'b0;
`ifdef CROP_READER_ROW_PAD_EN
      pad_r         <= '0;
`endif
    end else begin
      inflight      <= rd_en;
      inflight_sol  <= (c_cnt == 2'd0) && (y_cnt == 11'd0);
      inflight_last <= last_issue;
      if (start_ok) begin
        rows_r    <= rows;
        count_m1  <= 24'(cols) * 24'(rows) * 24'd3 - 24'd1;
        issue_idx <= '0;
        y_cnt     <= '0;
        c_cnt     <= '0;
        addr_r    <= ADDR_W'(BASE_ADDR);
`ifdef CROP_READER_ROW_PAD_EN
        pad_r     <= 2'd0 - rows_x3[1:0];
`endif
      end else if (rd_en) begin
        issue_idx <= issue_idx + 24'd1;
        if (c_cnt == 2'd2) begin
          c_cnt <= '0;
          y_cnt <= y_wrap ? 11'd0 : y_cnt + 11'd1;
        end else begin
          c_cnt <= c_cnt + 2'd1;
        end
`ifdef CROP_READER_ROW_PAD_EN
        addr_r <= addr_r + ADDR_W'(1) + (col_end ? {{(ADDR_W-2){1'b0}}, pad_r} : '0);
`else
        addr_r <= addr_r + ADDR_W'(1);
`endif
      end
    end
  end

  // Two-entry output buffer; the read credit rule keeps it from overflowing.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fifo_data[0] <= '0;
      fifo_data[1] <= '0;
      fifo_sol     <= '0;
      fifo_last    <= '0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      occ          <= '0;
    end else begin
      if (inflight) begin
        fifo_data[wr_ptr] <= rd_data;
        fifo_sol[wr_ptr]  <= inflight_sol;
        fifo_last[wr_ptr] <= inflight_last;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      occ <= occ + {1'b0, inflight} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_crop_stream_reader.sv
// Directed self-checking bench for crop_stream_reader with a one-cycle-latency memory model.
module tb_crop_stream_reader;

`ifdef CROP_READER_ROW_PAD_EN
  localparam int PadOn = 1;
`else
  localparam int PadOn = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [10:0] cols = '0;
  logic [10:0] rows = '0;
  logic        busy, done, rd_en, out_valid, out_sol, out_last;
  logic [23:0] rd_addr;
  logic [15:0] rd_data = '0;
  logic [15:0] out_data;
  logic        out_ready = 1'b1;

  int checkCount = 0;
  int passCount  = 0;
  int cyc = 0;
  int startCyc = 0;
  int readyMode = 0;
  int patIdx = 0;
  logic [3:0] readyPat = 4'b1001;

  int          addrQ[$];
  int          rdCycQ[$];
  logic [15:0] dataQ[$];
  logic        solQ[$];
  logic        lastQ[$];
  int          beatCycQ[$];
  int issuedTotal = 0, acceptedTotal = 0, maxOut = 0;
  bit anyValid = 0, doneSeen = 0, prevDone = 0, doneBusy = 0, stallPrev = 0;
  int doneCyc = 0;
  logic [15:0] prevData;
  logic prevSol, prevLast;

  crop_stream_reader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cols(cols), .rows(rows),
    .busy(busy), .done(done), .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sol(out_sol), .out_last(out_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] memWord(input int a);
    return 16'(a * 40503) ^ 16'h5A5A;
  endfunction

  always @(posedge clk) if (rd_en) rd_data <= memWord(int'(rd_addr));

  always begin
    @(posedge clk);
    #1;
    if (readyMode == 0) out_ready = 1'b1;
    else begin
      out_ready = readyPat[patIdx];
      patIdx = (patIdx + 1) % 4;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
  endtask

  // Record reads and accepted beats; verify payload holds steady while stalled.
  always @(negedge clk) begin
    if (rst_n) begin
      if (issuedTotal - acceptedTotal > maxOut) maxOut = issuedTotal - acceptedTotal;
      if (rd_en) begin
        addrQ.push_back(int'(rd_addr));
        rdCycQ.push_back(cyc);
        issuedTotal++;
      end
      if (out_valid) anyValid = 1;
      if (stallPrev) begin
        checkOutput("stall_valid", 32'(out_valid), 32'd1);
        checkOutput("stall_data", 32'(out_data), 32'(prevData));
        checkOutput("stall_flags", {30'd0, out_sol, out_last}, {30'd0, prevSol, prevLast});
      end
      if (out_valid && out_ready) begin
        dataQ.push_back(out_data);
        solQ.push_back(out_sol);
        lastQ.push_back(out_last);
        beatCycQ.push_back(cyc);
        acceptedTotal++;
      end
      stallPrev = out_valid && !out_ready;
      prevData  = out_data;
      prevSol   = out_sol;
      prevLast  = out_last;
      if (done && !prevDone && !doneSeen) begin
        doneSeen = 1;
        doneCyc  = cyc;
        doneBusy = busy;
      end
      prevDone = done;
    end else begin
      stallPrev = 0;
      prevDone  = 0;
    end
  end

  task automatic applyStimulus(input int c, input int r);
    @(posedge clk);
    #1;
    addrQ.delete(); rdCycQ.delete(); dataQ.delete();
    solQ.delete(); lastQ.delete(); beatCycQ.delete();
    issuedTotal = 0; acceptedTotal = 0; maxOut = 0;
    anyValid = 0; doneSeen = 0;
    cols = 11'(c);
    rows = 11'(r);
    start = 1'b1;
    @(posedge clk);
    #1;
    startCyc = cyc;
    start = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    int n;
    for (n = 0; n < budget; n++) begin
      @(negedge clk);
      #1;
      if (doneSeen) break;
    end
    if (n == budget) checkOutput("done_timeout", 32'd0, 32'd1);
  endtask

  // Expected addresses come from the packed/padded column-major layout.
  task automatic checkFrame(input string name, input int c, input int r, input bit fullRate);
    int n, colLen, pad, addr;
    n = c * r * 3;
    colLen = r * 3;
    pad = PadOn ? (4 - (colLen % 4)) % 4 : 0;
    checkOutput({name, "_beats"}, 32'(dataQ.size()), 32'(n));
    checkOutput({name, "_reads"}, 32'(addrQ.size()), 32'(n));
    addr = 54;
    for (int e = 0; e < n; e++) begin
      if (e < addrQ.size()) checkOutput({name, "_addr"}, 32'(addrQ[e]), 32'(addr));
      if (e < dataQ.size()) begin
        checkOutput({name, "_data"}, 32'(dataQ[e]), 32'(memWord(addr)));
        checkOutput({name, "_sol"}, 32'(solQ[e]), 32'((e % colLen) == 0));
        checkOutput({name, "_last"}, 32'(lastQ[e]), 32'(e == n - 1));
      end
      addr++;
      if (((e + 1) % colLen) == 0) addr += pad;
    end
    checkOutput({name, "_max_outstanding"}, 32'(maxOut <= 2), 32'd1);
    if (dataQ.size() == n && n > 0) begin
      checkOutput({name, "_done_lat"}, 32'(doneCyc), 32'(beatCycQ[n-1] + 1));
      checkOutput({name, "_busy_at_done"}, 32'(doneBusy), 32'd0);
      if (fullRate) begin
        checkOutput({name, "_first_rd"}, 32'(rdCycQ[0]), 32'(startCyc));
        checkOutput({name, "_first_beat"}, 32'(beatCycQ[0]), 32'(startCyc + 2));
        checkOutput({name, "_no_bubble"}, 32'(beatCycQ[n-1] - beatCycQ[0]), 32'(n - 1));
        checkOutput({name, "_rd_no_bubble"}, 32'(rdCycQ[n-1] - rdCycQ[0]), 32'(n - 1));
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_rd_en", 32'(rd_en), 32'd0);
    checkOutput("rst_rd_addr", 32'(rd_addr), 32'd54);
    checkOutput("rst_out", {13'd0, out_valid, out_sol, out_last, out_data}, 32'd0);
    rst_n = 1'b1;

    readyMode = 0;
    applyStimulus(2, 2);
    waitDone(100);
    checkFrame("full", 2, 2, 1'b1);

    readyMode = 1;
    patIdx = 0;
    applyStimulus(2, 2);
    waitDone(200);
    checkFrame("toggle", 2, 2, 1'b0);
    readyMode = 0;

    applyStimulus(0, 5);
    @(negedge clk);
    #1;
    checkOutput("zero_done", 32'(done), 32'd1);
    checkOutput("zero_busy", 32'(busy), 32'd0);
    repeat (5) @(negedge clk);
    #1;
    checkOutput("zero_reads", 32'(addrQ.size()), 32'd0);
    checkOutput("zero_valid", 32'(anyValid), 32'd0);

    applyStimulus(2, 1);
    waitDone(100);
    checkFrame("pad", 2, 1, 1'b1);

    applyStimulus(2, 2);
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      #1;
      if (dataQ.size() >= 5) break;
    end
    checkOutput("mid_beats", 32'(dataQ.size()), 32'd5);
    checkOutput("mid_inflight", 32'(issuedTotal - acceptedTotal > 0), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_done", 32'(done), 32'd0);
    checkOutput("mid_rst_rd_en", 32'(rd_en), 32'd0);
    checkOutput("mid_rst_rd_addr", 32'(rd_addr), 32'd54);
    checkOutput("mid_rst_out", {13'd0, out_valid, out_sol, out_last, out_data}, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("mid_no_stale", 32'(dataQ.size()), 32'd5);
    checkOutput("mid_idle", 32'(busy), 32'd0);
    applyStimulus(2, 2);
    waitDone(100);
    checkFrame("replay", 2, 2, 1'b1);

    checkOutput("pre_restart_done", 32'(done), 32'd1);
    applyStimulus(1, 1);
    @(negedge clk);
    #1;
    checkOutput("restart_done_drop", 32'(done), 32'd0);
    checkOutput("restart_busy", 32'(busy), 32'd1);
    waitDone(100);
    checkFrame("single", 1, 1, 1'b1);
    checkOutput("single_done_high", 32'(done), 32'd1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
